pipe_addsub: RTL and testbench



---
 rtl/pipe_addsub_pkg.sv | 25 ++
 rtl/pipe_addsub_if.sv | 29 ++
 rtl/pipe_addsub_slice.sv | 29 ++
 rtl/pipe_addsub.sv | 136 +++++++++++++
 tb/tb_pipe_addsub.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Holds the operation encodings and the signed-limit generator used by the saturating build.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int LIMIT_W = 64;

    // Returns the most positive (negative=0) or most negative (negative=1) two's-complement
    // value of the given width, zero-extended to LIMIT_W bits.
    function automatic logic [LIMIT_W-1:0] signed_limit(input int width, input logic negative);
        logic [LIMIT_W-1:0] r;
        r = '0;
        for (int i = 0; i < LIMIT_W; i++) begin
            if (i < width - 1) begin
                r[i] = !negative;
            end else if (i == width - 1) begin
                r[i] = negative;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// master = producer/consumer side, slave = the arithmetic pipeline.
interface pipe_addsub_if #(
    parameter int N = 8
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         select;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, c_in, select, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, select, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/pipe_addsub_slice.sv
// One carry-chain slice of pipe_addsub: a W-bit adder with registered sum and carry-out.
// The enable freezes the slice while the pipeline is stalled.
module addsub_slice #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else if (en) begin
            {c_out, sum} <= total;
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor with valid/ready handshake and signed-overflow flag.
// Define PIPE_ADDSUB_SAT_EN to clamp overflowing results to the signed extremes.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_addsub_if.slave  bus
);

    localparam int W = N / STAGES;

    logic              advance;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] carry;
    logic [N-1:0]      b_eff;
    logic              cin_eff;
    logic [N-1:0]      raw_sum;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              ovf_w;

    // Subtraction is folded into an add of ~b with an inverted carry-in.
    assign b_eff   = (bus.select == OP_SUB) ? ~bus.b : bus.b;
    assign cin_eff = (bus.select == OP_SUB) ? ~bus.c_in : bus.c_in;

    assign advance = !(valid[STAGES-1] && !bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (advance) begin
            valid[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid[k] <= valid[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Each stage only carries the operand bits it and later stages still need.
        localparam int HI = N - k * W;
        localparam int D  = STAGES - 1 - k;

        logic [HI-1:0] op_a;
        logic [HI-1:0] op_b;
        logic          carry_in;
        logic [W-1:0]  slice_sum;

        if (k == 0) begin : g_head
            assign op_a     = bus.a;
            assign op_b     = b_eff;
            assign carry_in = cin_eff;
        end else begin : g_skew
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_a <= '0;
                    op_b <= '0;
                end else if (advance) begin
                    op_a <= stg[k-1].op_a[HI+W-1:W];
                    op_b <= stg[k-1].op_b[HI+W-1:W];
                end
            end
            assign carry_in = carry[k-1];
        end

        addsub_slice #(
            .W(W)
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (advance),
            .a     (op_a[W-1:0]),
            .b     (op_b[W-1:0]),
            .c_in  (carry_in),
            .sum   (slice_sum),
            .c_out (carry[k])
        );

        if (D == 0) begin : g_direct
            assign raw_sum[k*W +: W] = slice_sum;
        end else begin : g_deskew
            logic [W-1:0] dly [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < D; j++) begin
                        dly[j] <= '0;
                    end
                end else if (advance) begin
                    dly[0] <= slice_sum;
                    for (int j = 1; j < D; j++) begin
                        dly[j] <= dly[j-1];
                    end
                end
            end

            assign raw_sum[k*W +: W] = dly[D-1];
        end

        if (k == STAGES - 1) begin : g_tail
            // Operand signs travel with the top slice so overflow lines up with the result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sign_a_q <= 1'b0;
                    sign_b_q <= 1'b0;
                end else if (advance) begin
                    sign_a_q <= op_a[W-1];
                    sign_b_q <= op_b[W-1];
                end
            end
        end
    end

    assign ovf_w = (sign_a_q == sign_b_q) && (raw_sum[N-1] != sign_a_q);

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid[STAGES-1];
    assign bus.c_out     = carry[STAGES-1];
    assign bus.ovf       = ovf_w;

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [LIMIT_W-1:0] SMAX_L = signed_limit(N, 1'b0);
    localparam logic [LIMIT_W-1:0] SMIN_L = signed_limit(N, 1'b1);
    localparam logic [N-1:0]       SMAX   = SMAX_L[N-1:0];
    localparam logic [N-1:0]       SMIN   = SMIN_L[N-1:0];

    assign bus.sum = ovf_w ? (sign_a_q ? SMIN : SMAX) : raw_sum;
`else
    assign bus.sum = raw_sum;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed cases on an N=8/STAGES=2 instance,
// then a boundary-value sweep with random backpressure on STAGES=1,2,4,8 instances.
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int N = 8;

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [7:0] SUB_OVF_SUM = 8'h80;
`else
    localparam logic [7:0] SUB_OVF_SUM = 8'h7F;
`endif

    logic        clk;
    logic        rst_n;
    int          total;
    int          bad;
    int          delivered;
    string       test_name;
    logic [9:0]  exp_q [$];
    logic [9:0]  mon_exp;
    bit          sweep_go;
    bit          sweep_done [4];

    pipe_addsub_if #(.N(N)) dut_if ();

    pipe_addsub #(
        .N      (N),
        .STAGES (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result packed as {ovf, c_out, sum}, built from the arithmetic definition.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sel);
        logic [7:0] bb;
        logic       ci;
        logic [8:0] full;
        logic       ov;
        logic [7:0] s;
        bb   = (sel == OP_SUB) ? ~b : b;
        ci   = (sel == OP_SUB) ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
        ov   = (a[7] == bb[7]) && (full[7] != a[7]);
        s    = full[7:0];
`ifdef PIPE_ADDSUB_SAT_EN
        if (ov) s = a[7] ? 8'h80 : 8'h7F;
`endif
        return {ov, full[8], s};
    endfunction

    // Presents one bundle, holds it until accepted, and records its expected result.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic sel, input logic [9:0] expected);
        dut_if.a        = a;
        dut_if.b        = b;
        dut_if.c_in     = cin;
        dut_if.select   = sel;
        dut_if.in_valid = 1'b1;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (dut_if.in_ready) begin
                exp_q.push_back(expected);
                @(posedge clk);
                #1;
                dut_if.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_output({test_name, "_accept_timeout"}, 32'd0, 32'd1);
        dut_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 64; w++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        check_output({test_name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("in_ready", 32'(dut_if.in_ready),
                         32'(!(dut_if.out_valid && !dut_if.out_ready)));
            if (dut_if.out_valid && dut_if.out_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    check_output({test_name, "_extra"}, 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_output({test_name, "_sum"}, 32'(dut_if.sum), 32'(mon_exp[7:0]));
                    check_output({test_name, "_c_out"}, 32'(dut_if.c_out), 32'(mon_exp[8]));
                    check_output({test_name, "_ovf"}, 32'(dut_if.ovf), 32'(mon_exp[9]));
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : sweep
        localparam int ST = 1 << g;

        pipe_addsub_if #(.N(N)) sw_if ();

        pipe_addsub #(
            .N      (N),
            .STAGES (ST)
        ) u_sw (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sw_if)
        );

        logic [9:0] sw_q [$];
        logic [9:0] sw_exp;
        bit         sw_running;

        initial begin : drive
            logic [7:0] pick [16];
            logic [9:0] ix;
            bit         accepted;
            pick = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h3F, 8'h40, 8'h55, 8'h7E,
                     8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC0, 8'hEF, 8'hFE, 8'hFF};
            sw_if.in_valid = 1'b0;
            sw_if.a        = '0;
            sw_if.b        = '0;
            sw_if.c_in     = 1'b0;
            sw_if.select   = 1'b0;
            sweep_done[g]  = 1'b0;
            sw_running     = 1'b0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            sw_running = 1'b1;
            for (int idx = 0; idx < 1024; idx++) begin
                ix = 10'(idx);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                sw_if.a        = pick[ix[9:6]];
                sw_if.b        = pick[ix[5:2]];
                sw_if.c_in     = ix[1];
                sw_if.select   = ix[0];
                sw_if.in_valid = 1'b1;
                accepted       = 1'b0;
                for (int w = 0; w < 100 && !accepted; w++) begin
                    @(negedge clk);
                    if (sw_if.in_ready) begin
                        sw_q.push_back(model(sw_if.a, sw_if.b, sw_if.c_in, sw_if.select));
                        accepted = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                end
                if (!accepted) check_output($sformatf("sweep_s%0d_accept_timeout", ST), 32'd0, 32'd1);
                sw_if.in_valid = 1'b0;
            end
            for (int w = 0; w < 400 && sw_q.size() != 0; w++) begin
                @(posedge clk);
                #1;
            end
            check_output($sformatf("sweep_s%0d_drain", ST), 32'(sw_q.size()), 32'd0);
            sw_running    = 1'b0;
            sweep_done[g] = 1'b1;
        end

        initial begin : ready_gen
            sw_if.out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                sw_if.out_ready = sw_running ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                check_output($sformatf("sweep_s%0d_in_ready", ST), 32'(sw_if.in_ready),
                             32'(!(sw_if.out_valid && !sw_if.out_ready)));
                if (sw_if.out_valid && sw_if.out_ready) begin
                    if (sw_q.size() == 0) begin
                        check_output($sformatf("sweep_s%0d_extra", ST), 32'd1, 32'd0);
                    end else begin
                        sw_exp = sw_q.pop_front();
                        check_output($sformatf("sweep_s%0d_result", ST),
                                     32'({sw_if.ovf, sw_if.c_out, sw_if.sum}), 32'(sw_exp));
                    end
                end
            end
        end
    end

    initial begin
        int  d0;
        bit  all_done;
        total            = 0;
        bad              = 0;
        delivered        = 0;
        sweep_go         = 1'b0;
        test_name        = "reset";
        rst_n            = 1'b0;
        dut_if.in_valid  = 1'b0;
        dut_if.a         = '0;
        dut_if.b         = '0;
        dut_if.c_in      = 1'b0;
        dut_if.select    = OP_ADD;
        dut_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("reset_out_valid", 32'(dut_if.out_valid), 32'd0);
        check_output("reset_sum", 32'(dut_if.sum), 32'd0);
        check_output("reset_c_out", 32'(dut_if.c_out), 32'd0);
        check_output("reset_ovf", 32'(dut_if.ovf), 32'd0);
        check_output("reset_in_ready", 32'(dut_if.in_ready), 32'd1);

        test_name = "add_carry";
        apply_stimulus(8'hFF, 8'h01, 1'b0, OP_ADD, {1'b0, 1'b1, 8'h00});
        check_output("add_carry_latency_early", 32'(dut_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_output("add_carry_latency", 32'(dut_if.out_valid), 32'd1);
        wait_drain();

        test_name = "sub_ovf";
        apply_stimulus(8'h80, 8'h01, 1'b0, OP_SUB, {1'b1, 1'b1, SUB_OVF_SUM});
        wait_drain();

        test_name = "borrow_in";
        apply_stimulus(8'h05, 8'h03, 1'b1, OP_SUB, {1'b0, 1'b1, 8'h01});
        apply_stimulus(8'h00, 8'h00, 1'b1, OP_SUB, {1'b0, 1'b0, 8'hFF});
        wait_drain();

        test_name = "backpressure";
        d0 = delivered;
        fork
            begin
                for (int c = 0; c < 12; c++) begin
                    dut_if.out_ready = !(c >= 3 && c <= 5);
                    @(posedge clk);
                    #1;
                end
                dut_if.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    apply_stimulus(8'(i), 8'(i), 1'b0, OP_ADD, {2'b00, 8'(2 * i)});
                end
            end
        join
        wait_drain();
        check_output("backpressure_count", 32'(delivered - d0), 32'd8);

        test_name = "reset_mid";
        apply_stimulus(8'h11, 8'h22, 1'b0, OP_ADD, {2'b00, 8'h33});
        apply_stimulus(8'h01, 8'h02, 1'b0, OP_ADD, {2'b00, 8'h03});
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("reset_mid_out_valid", 32'(dut_if.out_valid), 32'd0);
        check_output("reset_mid_sum", 32'(dut_if.sum), 32'd0);
        check_output("reset_mid_in_ready", 32'(dut_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output("reset_mid_no_stale", 32'(dut_if.out_valid), 32'd0);

        test_name = "sweep";
        sweep_go  = 1'b1;
        all_done  = 1'b0;
        for (int c = 0; c < 40000 && !all_done; c++) begin
            @(posedge clk);
            all_done = sweep_done[0] && sweep_done[1] && sweep_done[2] && sweep_done[3];
        end
        check_output("sweep_complete", 32'(all_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
